// File: rtl/sysbus_mem_if_if.sv
// Control/pad signal bundle for the SysBus memory responder.
// The tristate SysBus itself stays a plain inout on the module so the pad driver remains a simple wire.
interface sysbus_mem_if_if #(
  parameter int WIDTH = 16
);
  logic             AddrLoad;
  logic             MemRead;
  logic             MemWrite;
  logic             MdrEn;
  logic             Test;
  logic [WIDTH-1:0] Address;
  logic [WIDTH-1:0] MemDataOut;
  logic [WIDTH-1:0] MemDataIn;
  logic             nME;
  logic             nOE;
  logic             nWE;
  logic             nWait;
  logic             Ready;
  logic             BusErr;

  modport slave (
    input  AddrLoad, MemRead, MemWrite, MdrEn, Test, MemDataIn, nWait,
    output Address, MemDataOut, nME, nOE, nWE, Ready, BusErr
  );

  modport master (
    output AddrLoad, MemRead, MemWrite, MdrEn, Test, MemDataIn, nWait,
    input  Address, MemDataOut, nME, nOE, nWE, Ready, BusErr
  );
endinterface

// File: rtl/sysbus_mem_if.sv
// SysBus memory responder: latches an address, runs a timed async-SRAM read/write
// cycle with nWait extension and timeout, and returns read data onto SysBus.
module sysbus_mem_if #(
  parameter int WIDTH         = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_WAIT      = 15
) (
  input  logic             Clock,
  input  logic             nReset,
  inout  wire  [WIDTH-1:0] SysBus,
  sysbus_mem_if_if.slave   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [3:0] CNT_LOAD  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  logic [2:0]       r_state;
  logic [3:0]       r_cnt;
  logic [3:0]       r_wcnt;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_nme;
  logic             r_noe;
  logic             r_nwe;
  logic             r_ready;
  logic             r_buserr;

  logic w_is_rd;
  logic w_access;
  logic w_waiting;
  logic w_timeout;
  logic w_finish;
  logic w_drive;

  assign w_is_rd   = (r_state == S_RD) || (r_state == S_RD_WAIT);
  assign w_access  = (r_state == S_RD) || (r_state == S_WR);
  assign w_waiting = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_timeout = w_waiting && !bus.nWait && (r_wcnt == WAIT_LAST);
  // The cycle ends on the first edge past the access time with nWait released, or on timeout.
  assign w_finish  = (w_access && (r_cnt == 4'd0) && bus.nWait)
                   || (w_waiting && bus.nWait) || w_timeout;

  always_ff @(posedge Clock or negedge nReset) begin
    // NOTE: data registers are reset too, so the pads and SysBus never show stale contents after reset.
    if (!nReset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wcnt   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_nme    <= 1'b1;
      r_noe    <= 1'b1;
      r_nwe    <= 1'b1;
      r_ready  <= 1'b0;
      r_buserr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (bus.AddrLoad) r_addr <= SysBus;
      if (!bus.Test) begin
        r_ready <= 1'b0;
        if (w_finish) begin
          r_state <= S_DONE;
          r_ready <= 1'b1;
          r_nme   <= 1'b1;
          r_noe   <= 1'b1;
          r_nwe   <= 1'b1;
          if (w_timeout) r_buserr <= 1'b1;
          if (w_is_rd)   r_rdata  <= w_timeout ? '1 : bus.MemDataIn;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (bus.MemRead) begin
                r_state  <= S_RD;
                r_cnt    <= CNT_LOAD;
                r_buserr <= 1'b0;
                r_nme    <= 1'b0;
                r_noe    <= 1'b0;
              end else if (bus.MemWrite) begin
                r_state  <= S_WR;
                r_cnt    <= CNT_LOAD;
                r_buserr <= 1'b0;
                r_wdata  <= SysBus;
                r_nme    <= 1'b0;
                r_nwe    <= 1'b0;
              end
            end
            S_RD, S_WR: begin
              if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
              end else begin
                r_state <= w_is_rd ? S_RD_WAIT : S_WR_WAIT;
                r_wcnt  <= '0;
              end
            end
            S_RD_WAIT, S_WR_WAIT: r_wcnt <= r_wcnt + 4'd1;
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Test mode overrides the registered strobes without disturbing the frozen cycle.
  assign bus.nME        = r_nme | bus.Test;
  assign bus.nOE        = r_noe | bus.Test;
  assign bus.nWE        = r_nwe | bus.Test;
  assign bus.Ready      = r_ready;
  assign bus.BusErr     = r_buserr;
  assign bus.Address    = r_addr;
  assign bus.MemDataOut = r_wdata;

  assign w_drive = bus.MdrEn && !bus.Test;
  assign SysBus  = w_drive ? r_rdata : 'z;

endmodule

// File: tb/tb_sysbus_mem_if.sv
// Bench for sysbus_mem_if: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a cycle-count model of the access rules.
module tb_sysbus_mem_if;

  localparam int A = 2;
  localparam int M = 15;

  logic        Clock  = 1'b0;
  logic        nReset = 1'b1;
  logic        tb_en  = 1'b0;
  logic [15:0] tb_val = '0;
  wire  [15:0] SysBus;

  assign SysBus = tb_en ? tb_val : 'z;

  sysbus_mem_if_if #(.WIDTH(16)) bus ();

  sysbus_mem_if #(.WIDTH(16), .ACCESS_CYCLES(A), .MAX_WAIT(M)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .SysBus (SysBus),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: an access lasts until the first edge at least A edges after the
  // request that sees nWait high, or is cut off at edge A+M; then one Ready cycle.
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;
  int          m_phase   = P_IDLE;
  int          m_elapsed = 0;
  bit          m_read    = 1'b0;
  logic [15:0] m_addr    = '0;
  logic [15:0] m_wdata   = '0;
  logic [15:0] m_rdata   = '0;
  bit          m_buserr  = 1'b0;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_phase = P_IDLE; m_elapsed = 0; m_read = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_buserr = 1'b0;
    end else begin
      if (bus.AddrLoad) m_addr = tb_val;
      if (!bus.Test) begin
        if (m_phase == P_DONE) begin
          m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
          if (bus.MemRead || bus.MemWrite) begin
            m_phase = P_BUSY; m_elapsed = 0; m_buserr = 1'b0;
            m_read = bus.MemRead;
            if (!bus.MemRead) m_wdata = tb_val;
          end
        end else begin
          m_elapsed++;
          if (m_elapsed >= A && bus.nWait) begin
            m_phase = P_DONE;
            if (m_read) m_rdata = bus.MemDataIn;
          end else if (m_elapsed == A + M) begin
            m_phase = P_DONE; m_buserr = 1'b1;
            if (m_read) m_rdata = 16'hFFFF;
          end
        end
      end
    end
  end

  always @(negedge Clock) begin
    bit busy;
    busy = (m_phase == P_BUSY) && !bus.Test;
    check("Address",    bus.Address,    m_addr);
    check("MemDataOut", bus.MemDataOut, m_wdata);
    check("nME",        bus.nME,        !busy);
    check("nOE",        bus.nOE,        !(busy && m_read));
    check("nWE",        bus.nWE,        !(busy && !m_read));
    check("Ready",      bus.Ready,      m_phase == P_DONE);
    check("BusErr",     bus.BusErr,     m_buserr);
    if (bus.MdrEn && !bus.Test) check("SysBus_drive", SysBus, m_rdata);
    else if (tb_en)             check("SysBus_release", SysBus, tb_val);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  // Called just after the request edge; counts strobe clocks and finds the edge that samples Ready.
  task automatic run_cycle(input int wait_edges, input logic [15:0] din_base,
                           output int ready_edge, output int low_nme,
                           output int low_noe, output int low_nwe);
    bit got = 1'b0;
    ready_edge = 0; low_nme = 0; low_noe = 0; low_nwe = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (bus.Ready) begin
        got = 1'b1;
        ready_edge = k + 1;
      end else begin
        low_nme += (bus.nME == 1'b0) ? 1 : 0;
        low_noe += (bus.nOE == 1'b0) ? 1 : 0;
        low_nwe += (bus.nWE == 1'b0) ? 1 : 0;
        bus.nWait     = (k + 1 < A + wait_edges) ? 1'b0 : 1'b1;
        bus.MemDataIn = din_base + 16'(k + 1);
        step(1);
      end
    end
    check("ready_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic request(input bit rd, input bit wr, input logic [15:0] val);
    tb_en = 1'b1; tb_val = val;
    bus.MemRead = rd; bus.MemWrite = wr;
    step(1);
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; tb_en = 1'b0;
  endtask

  initial begin
    int re, ln, lo, lw;
    bit seen;
    bus.AddrLoad = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.MdrEn = 1'b0; bus.Test = 1'b0; bus.nWait = 1'b1; bus.MemDataIn = '0;
    #1 nReset = 1'b0;
    step(2);
    check("rst_Address", bus.Address, 16'h0000);
    check("rst_nME",     bus.nME,     1'b1);
    check("rst_Ready",   bus.Ready,   1'b0);
    nReset = 1'b1;

    // Address load and plain read
    tb_en = 1'b1; tb_val = 16'h0040; bus.AddrLoad = 1'b1;
    step(1);
    bus.AddrLoad = 1'b0; tb_en = 1'b0;
    check("addr_load", bus.Address, 16'h0040);
    request(1'b1, 1'b0, 16'h0000);
    run_cycle(0, 16'hBEEE, re, ln, lo, lw);  // captured at edge 2: BEEE+... overwritten below
    check("rd_ready_edge", re, 3);
    check("rd_nme_clocks", ln, 2);
    check("rd_noe_clocks", lo, 2);
    check("rd_nwe_clocks", lw, 0);
    check("model_rdata",   m_rdata, 16'hBEF0);
    step(1);
    check("rd_ready_1cyc", bus.Ready, 1'b0);
    bus.MdrEn = 1'b1; #1;
    check("rd_sysbus", SysBus, 16'hBEF0);
    bus.MdrEn = 1'b0; tb_en = 1'b1; tb_val = 16'h5A5A; #1;
    check("rd_release", SysBus, 16'h5A5A);
    tb_en = 1'b0;

    // Write
    request(1'b0, 1'b1, 16'h1234);
    check("wr_mdo", bus.MemDataOut, 16'h1234);
    run_cycle(0, 16'h0000, re, ln, lo, lw);
    check("wr_ready_edge", re, 3);
    check("wr_nwe_clocks", lw, 2);
    check("wr_noe_clocks", lo, 0);
    check("wr_buserr",     bus.BusErr, 1'b0);
    step(1);

    // Read extended by three wait edges
    request(1'b1, 1'b0, 16'h0000);
    run_cycle(3, 16'h1000, re, ln, lo, lw);
    check("wait_ready_edge", re, 6);
    check("wait_nme_clocks", ln, 5);
    step(1);
    bus.MdrEn = 1'b1; #1;
    check("wait_data", SysBus, 16'h1005);
    bus.MdrEn = 1'b0;

    // nWait stuck low: timeout
    request(1'b1, 1'b0, 16'h0000);
    run_cycle(999, 16'h2000, re, ln, lo, lw);
    check("to_ready_edge", re, 18);
    check("to_nme_clocks", ln, 17);
    check("to_buserr",     bus.BusErr, 1'b1);
    check("model_buserr",  {31'd0, m_buserr}, 32'd1);
    step(1);
    bus.MdrEn = 1'b1; #1;
    check("to_data", SysBus, 16'hFFFF);
    bus.MdrEn = 1'b0;
    request(1'b1, 1'b0, 16'h0000);
    check("to_clear", bus.BusErr, 1'b0);
    run_cycle(0, 16'h3000, re, ln, lo, lw);
    check("to_next_ready", re, 3);
    step(1);

    // Read and write together, then reset mid-read
    request(1'b1, 1'b1, 16'hABCD);
    check("both_nwe", bus.nWE, 1'b1);
    check("both_noe", bus.nOE, 1'b0);
    check("both_mdo", bus.MemDataOut, 16'h1234);
    step(1);
    nReset = 1'b0; #1;
    check("rstmid_nme", bus.nME, 1'b1);
    check("rstmid_noe", bus.nOE, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      seen |= bus.Ready;
    end
    check("rstmid_noready", {31'd0, seen}, 32'd0);
    nReset = 1'b1;
    step(1);

    // Test mode freezes mid-read
    request(1'b1, 1'b0, 16'h0000);
    bus.Test = 1'b1; #1;
    check("test_nme", bus.nME, 1'b1);
    check("test_noe", bus.nOE, 1'b1);
    step(3);
    check("test_frozen_ready", bus.Ready, 1'b0);
    bus.MdrEn = 1'b1; tb_en = 1'b1; tb_val = 16'hC3C3; #1;
    check("test_release", SysBus, 16'hC3C3);
    bus.MdrEn = 1'b0; tb_en = 1'b0;
    bus.Test = 1'b0; #1;
    check("test_resume_noe", bus.nOE, 1'b0);
    run_cycle(0, 16'h7000, re, ln, lo, lw);
    check("test_ready_edge", re, 3);
    check("test_nme_clocks", ln, 2);
    step(1);
    bus.MdrEn = 1'b1; #1;
    check("test_data", SysBus, 16'h7002);
    bus.MdrEn = 1'b0;

    // Randomized traffic; every third block of 100 cycles holds nWait mostly low to force timeouts
    for (int i = 0; i < 1500; i++) begin
      bus.Test     = ($urandom_range(0, 99) < 3);
      bus.MdrEn    = ($urandom_range(0, 99) < 30);
      bus.MemRead  = ($urandom_range(0, 99) < 15);
      bus.MemWrite = ($urandom_range(0, 99) < 15);
      bus.AddrLoad = ($urandom_range(0, 99) < 10);
      if (bus.MdrEn) begin
        bus.AddrLoad = 1'b0; bus.MemWrite = 1'b0; tb_en = 1'b0;
      end else begin
        tb_en = 1'b1;
      end
      tb_val        = 16'($urandom);
      bus.MemDataIn = 16'($urandom);
      bus.nWait     = ((i / 100) % 3 == 2) ? ($urandom_range(0, 99) < 3)
                                            : ($urandom_range(0, 99) < 70);
      step(1);
    end
    bus.Test = 1'b0; bus.MdrEn = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.AddrLoad = 1'b0; bus.nWait = 1'b1; tb_en = 1'b0;
    step(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sysbus_mem_if.md
Name: sysbus_mem_if

Overview:
- Memory-side responder on the processor SysBus: the far end of the bus that the PC slice and register slices drive addresses and data onto.
- Latches an address from SysBus, runs a timed read or write cycle on the external asynchronous SRAM strobes, and returns read data onto SysBus through a tristate driver.
- Sits between the datapath SysBus and the pad ring; sequenced by the control unit via request/ready handshake.

Parameters:
WIDTH, 16, SysBus/address/data width
ACCESS_CYCLES, 2, minimum clocks a strobe is held active (1..15)
MAX_WAIT, 15, clocks nWait may extend a cycle before timeout (1..15)

Ports:
Clock  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
Test  input  1  scan/test mode; forces strobes inactive and SysBus undriven
SysBus  inout  WIDTH  shared tristate system bus
AddrLoad  input  1  capture SysBus into address register this edge
MemRead  input  1  start read cycle (sampled in IDLE only)
MemWrite  input  1  start write cycle, write data taken from SysBus this edge
MdrEn  input  1  drive read-data register onto SysBus
Address  output  WIDTH  latched memory address to pads
MemDataOut  output  WIDTH  write data to pads
MemDataIn  input  WIDTH  read data from pads
nME  output  1  memory enable, active low
nOE  output  1  output enable, active low
nWE  output  1  write enable, active low
nWait  input  1  memory wait request, active low
Ready  output  1  one-cycle pulse: cycle complete
BusErr  output  1  sticky timeout flag, cleared by next accepted request

Behaviour:
- Reset (asynchronous): Address=0, MemDataOut=0, read-data register=0, nME=nOE=nWE=1, Ready=0, BusErr=0, FSM=IDLE. Assertion mid-cycle aborts immediately; no Ready is issued.
- Address register loads SysBus on any edge with AddrLoad=1, in any state. The control unit is responsible for holding AddrLoad low during an active cycle.
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE.
- IDLE:
  - MemRead=1 -> RD; cnt=ACCESS_CYCLES-1; BusErr cleared.
  - MemWrite=1 -> WR; MemDataOut<=SysBus; cnt loaded; BusErr cleared.
  - Both high: read has priority, write is ignored (not queued).
  - Requests in any other state are ignored.
- RD: nME=0, nOE=0.
  - cnt>0: decrement.
  - cnt==0 and nWait=1: capture MemDataIn into read-data register -> DONE.
  - cnt==0 and nWait=0: -> RD_WAIT, wcnt=0.
- RD_WAIT: strobes held.
  - nWait=1: capture -> DONE.
  - nWait=0: wcnt++.
  - wcnt==MAX_WAIT-1 with nWait still 0: BusErr=1, read-data register loaded with all ones -> DONE.
- WR / WR_WAIT: same timing as RD / RD_WAIT with nME=0, nWE=0, nOE=1. Timeout sets BusErr only.
- DONE: all strobes inactive, Ready=1 for exactly this cycle -> IDLE.
- Latency without wait: request edge to Ready = ACCESS_CYCLES+1 clocks. Strobes are active for exactly ACCESS_CYCLES clocks.
- Strobes are registered outputs; they must not glitch and nOE/nWE are never low together.
- SysBus driven with read-data register iff MdrEn=1 and Test=0; otherwise high-Z. MdrEn is combinational to the driver and independent of FSM state.
- Test=1:
  - nME/nOE/nWE forced to 1 combinationally.
  - FSM frozen in its current state; counters hold.
  - SysBus released.

Test Plan:
- Reset, drive SysBus=16'h0040 with AddrLoad=1, then MemRead, MemDataIn=16'hBEEF, nWait=1 -> Address=16'h0040; nME/nOE low for exactly 2 clocks; Ready pulses at request+3; with MdrEn=1, SysBus==16'hBEEF; with MdrEn=0, SysBus==Z.
- Write: SysBus=16'h1234 with MemWrite=1 -> MemDataOut=16'h1234; nWE low for 2 clocks; nOE stays 1; Ready one cycle; BusErr=0.
- Read with nWait=0 for 3 extra clocks -> strobes held 5 clocks; data captured on the first nWait=1 edge; Ready at request+6.
- nWait stuck 0 -> after 2+15 active clocks, BusErr=1, read data=16'hFFFF, Ready pulses; the next MemRead clears BusErr.
- MemRead and MemWrite together -> read cycle only; nWE never asserted; MemDataOut unchanged. Then pull nReset low mid-RD -> strobes return to 1 at once, no Ready.
- Test=1 mid-read -> strobes go to 1 and SysBus goes to Z. Test=0 -> cycle resumes from the frozen count and completes with Ready.
